// File: rtl/tag_lru_array.sv
// Set-associative tag store with per-set age-based LRU replacement and a
// sequential whole-array invalidation engine.
module tag_lru_array #(
    parameter int WAYS  = 2,
    parameter int SETS  = 64,
    parameter int TAG_W = 6,
    localparam int SW = $clog2(SETS),
    localparam int WW = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lookup_valid,
    input  logic [SW-1:0]    lookup_set,
    input  logic [TAG_W-1:0] lookup_tag,
    input  logic             fill_valid,
    input  logic [SW-1:0]    fill_set,
    input  logic [WW-1:0]    fill_way,
    input  logic [TAG_W-1:0] fill_tag,
    input  logic             inv_all,
    output logic             lookup_done,
    output logic             hit,
    output logic [WW-1:0]    hit_way,
    output logic [WW-1:0]    victim_way,
    output logic             busy
);

    typedef enum logic {IDLE, FLUSH} state_t;
    typedef logic [WAYS-1:0][WW-1:0] ages_t;

    state_t                      state_q, state_d;
    logic [SW-1:0]               cnt_q, cnt_d;
    logic [WAYS-1:0]             valid_q [SETS];
    logic [WAYS-1:0]             valid_d [SETS];
    logic [WAYS-1:0][TAG_W-1:0]  tag_q   [SETS];
    logic [WAYS-1:0][TAG_W-1:0]  tag_d   [SETS];
    ages_t                       age_q   [SETS];
    ages_t                       age_d   [SETS];
    logic                        lookup_done_q, lookup_done_d;
    logic                        hit_q, hit_d;
    logic [WW-1:0]               hit_way_q, hit_way_d;
    logic [WW-1:0]               victim_q, victim_d;
    logic                        busy_q, busy_d;

    logic                        hit_c;
    logic [WW-1:0]               hit_way_c;
    logic [WW-1:0]               victim_c;
    logic                        inv_found;

    function automatic ages_t init_ages();
        ages_t a;
        for (int unsigned w = 0; w < WAYS; w++) a[w] = WW'(w);
        return a;
    endfunction

    // Ways younger than the touched way age by one; the touched way becomes MRU.
    function automatic ages_t touch(input ages_t ages, input logic [WW-1:0] way);
        ages_t a;
        a = ages;
        for (int unsigned i = 0; i < WAYS; i++)
            if (ages[i] < ages[way]) a[i] = ages[i] + 1'b1;
        a[way] = '0;
        return a;
    endfunction

    always_comb begin
        hit_c     = 1'b0;
        hit_way_c = '0;
        victim_c  = '0;
        inv_found = 1'b0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (!hit_c && valid_q[lookup_set][i] && tag_q[lookup_set][i] == lookup_tag) begin
                hit_c     = 1'b1;
                hit_way_c = WW'(i);
            end
            if (age_q[lookup_set][i] == WW'(WAYS - 1)) victim_c = WW'(i);
        end
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (!inv_found && !valid_q[lookup_set][i]) begin
                inv_found = 1'b1;
                victim_c  = WW'(i);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        valid_d       = valid_q;
        tag_d         = tag_q;
        age_d         = age_q;
        lookup_done_d = 1'b0;
        hit_d         = hit_q;
        hit_way_d     = hit_way_q;
        victim_d      = victim_q;
        case (state_q)
            IDLE: begin
                if (lookup_valid) begin
                    lookup_done_d = 1'b1;
                    hit_d         = hit_c;
                    hit_way_d     = hit_way_c;
                    victim_d      = victim_c;
                    // A fill to the same set wins; its touch alone is applied.
                    if (hit_c && !(fill_valid && fill_set == lookup_set))
                        age_d[lookup_set] = touch(age_q[lookup_set], hit_way_c);
                end
                if (fill_valid) begin
                    tag_d[fill_set][fill_way]   = fill_tag;
                    valid_d[fill_set][fill_way] = 1'b1;
                    age_d[fill_set]             = touch(age_q[fill_set], fill_way);
                end
                if (inv_all) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            FLUSH: begin
                valid_d[cnt_q] = '0;
                age_d[cnt_q]   = init_ages();
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == SW'(SETS - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == FLUSH);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            lookup_done_q <= 1'b0;
            hit_q         <= 1'b0;
            hit_way_q     <= '0;
            victim_q      <= '0;
            busy_q        <= 1'b0;
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                tag_q[s]   <= '0;
                age_q[s]   <= init_ages();
            end
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            valid_q       <= valid_d;
            tag_q         <= tag_d;
            age_q         <= age_d;
            lookup_done_q <= lookup_done_d;
            hit_q         <= hit_d;
            hit_way_q     <= hit_way_d;
            victim_q      <= victim_d;
            busy_q        <= busy_d;
        end
    end

    assign lookup_done = lookup_done_q;
    assign hit         = hit_q;
    assign hit_way     = hit_way_q;
    assign victim_way  = victim_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_tag_lru_array.sv
// Directed bench for tag_lru_array: a 2-way and a 4-way instance driven with
// hand-computed vectors covering lookup, fill, LRU ordering, flush and reset.
module tb_tag_lru_array;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       lookup_valid, fill_valid, inv_all;
    logic [5:0] lookup_set, fill_set, lookup_tag, fill_tag;
    logic       fill_way;
    logic       lookup_done, hit, hit_way, victim_way, busy;

    logic       lookup_valid4, fill_valid4, inv_all4;
    logic [5:0] lookup_set4, fill_set4, lookup_tag4, fill_tag4;
    logic [1:0] fill_way4;
    logic       lookup_done4, hit4, busy4;
    logic [1:0] hit_way4, victim_way4;

    int checks = 0;
    int failures = 0;
    int n;

    always #5 clk = ~clk;

    tag_lru_array #(.WAYS(2), .SETS(64), .TAG_W(6)) u_dut2 (
        .clk(clk), .rst(rst),
        .lookup_valid(lookup_valid), .lookup_set(lookup_set), .lookup_tag(lookup_tag),
        .fill_valid(fill_valid), .fill_set(fill_set), .fill_way(fill_way), .fill_tag(fill_tag),
        .inv_all(inv_all),
        .lookup_done(lookup_done), .hit(hit), .hit_way(hit_way),
        .victim_way(victim_way), .busy(busy)
    );

    tag_lru_array #(.WAYS(4), .SETS(64), .TAG_W(6)) u_dut4 (
        .clk(clk), .rst(rst),
        .lookup_valid(lookup_valid4), .lookup_set(lookup_set4), .lookup_tag(lookup_tag4),
        .fill_valid(fill_valid4), .fill_set(fill_set4), .fill_way(fill_way4), .fill_tag(fill_tag4),
        .inv_all(inv_all4),
        .lookup_done(lookup_done4), .hit(hit4), .hit_way(hit_way4),
        .victim_way(victim_way4), .busy(busy4)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill2(input logic [5:0] s, input logic w, input logic [5:0] t);
        fill_valid = 1'b1; fill_set = s; fill_way = w; fill_tag = t;
        tick();
        fill_valid = 1'b0;
    endtask

    task automatic lookup2(input logic [5:0] s, input logic [5:0] t);
        lookup_valid = 1'b1; lookup_set = s; lookup_tag = t;
        tick();
        lookup_valid = 1'b0;
    endtask

    task automatic fill4(input logic [5:0] s, input logic [1:0] w, input logic [5:0] t);
        fill_valid4 = 1'b1; fill_set4 = s; fill_way4 = w; fill_tag4 = t;
        tick();
        fill_valid4 = 1'b0;
    endtask

    task automatic lookup4(input logic [5:0] s, input logic [5:0] t);
        lookup_valid4 = 1'b1; lookup_set4 = s; lookup_tag4 = t;
        tick();
        lookup_valid4 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        lookup_valid = 0; fill_valid = 0; inv_all = 0;
        lookup_set = 0; lookup_tag = 0; fill_set = 0; fill_way = 0; fill_tag = 0;
        lookup_valid4 = 0; fill_valid4 = 0; inv_all4 = 0;
        lookup_set4 = 0; lookup_tag4 = 0; fill_set4 = 0; fill_way4 = 0; fill_tag4 = 0;

        repeat (3) tick();
        check("rst_lookup_done", lookup_done, 0);
        check("rst_hit", hit, 0);
        check("rst_hit_way", hit_way, 0);
        check("rst_victim", victim_way, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1;
        tick();

        // Empty array lookup
        lookup2(6'd5, 6'h2A);
        check("empty_done", lookup_done, 1);
        check("empty_hit", hit, 0);
        check("empty_victim", victim_way, 0);
        tick();
        check("done_one_cycle", lookup_done, 0);

        // Two-way fill then hit/miss
        fill2(6'd5, 1'b0, 6'h2A);
        fill2(6'd5, 1'b1, 6'h11);
        lookup2(6'd5, 6'h2A);
        check("w2_hit", hit, 1);
        check("w2_hit_way", hit_way, 0);
        lookup2(6'd5, 6'h3F);
        check("w2_miss_hit", hit, 0);
        check("w2_miss_hit_way", hit_way, 0);
        check("w2_miss_victim", victim_way, 1);

        // Four-way LRU ordering
        fill4(6'd7, 2'd0, 6'h10);
        fill4(6'd7, 2'd1, 6'h11);
        fill4(6'd7, 2'd2, 6'h12);
        fill4(6'd7, 2'd3, 6'h13);
        lookup4(6'd7, 6'h11);
        check("w4_hit1", hit4, 1);
        check("w4_hit1_way", hit_way4, 1);
        lookup4(6'd7, 6'h3E);
        check("w4_miss1_hit", hit4, 0);
        check("w4_miss1_victim", victim_way4, 0);
        lookup4(6'd7, 6'h10);
        check("w4_hit0_way", hit_way4, 0);
        lookup4(6'd7, 6'h3E);
        check("w4_miss2_victim", victim_way4, 2);

        // Flush with ignored requests part way through
        inv_all = 1'b1;
        tick();
        inv_all = 1'b0;
        check("flush_busy_start", busy, 1);
        n = 0;
        while (busy && n < 200) begin
            if (n == 2) begin
                lookup_valid = 1; lookup_set = 6'd5; lookup_tag = 6'h2A;
                fill_valid = 1; fill_set = 6'd0; fill_way = 0; fill_tag = 6'h15;
                inv_all = 1;
            end
            if (n == 3) begin
                check("busy_lookup_done", lookup_done, 0);
                lookup_valid = 0; fill_valid = 0; inv_all = 0;
            end
            n++;
            tick();
        end
        check("busy_cycles", n, 64);
        lookup2(6'd5, 6'h2A);
        check("post_flush_done", lookup_done, 1);
        check("post_flush_hit", hit, 0);
        check("post_flush_victim", victim_way, 0);
        lookup2(6'd0, 6'h15);
        check("busy_fill_ignored", hit, 0);
        check("no_reflush", busy, 0);

        // Same-cycle lookup and fill to one set
        fill2(6'd5, 1'b0, 6'h2A);
        fill2(6'd5, 1'b1, 6'h11);
        lookup_valid = 1; lookup_set = 6'd5; lookup_tag = 6'h11;
        fill_valid = 1; fill_set = 6'd5; fill_way = 1; fill_tag = 6'h22;
        tick();
        lookup_valid = 0; fill_valid = 0;
        check("same_set_hit", hit, 1);
        check("same_set_hit_way", hit_way, 1);
        check("same_set_victim", victim_way, 0);
        lookup2(6'd5, 6'h11);
        check("after_fill_hit", hit, 0);
        check("after_fill_victim", victim_way, 0);

        // Same-cycle lookup and fill to different sets
        lookup_valid = 1; lookup_set = 6'd5; lookup_tag = 6'h2A;
        fill_valid = 1; fill_set = 6'd9; fill_way = 0; fill_tag = 6'h01;
        tick();
        lookup_valid = 0; fill_valid = 0;
        check("diff_set_hit", hit, 1);
        lookup2(6'd5, 6'h3F);
        check("diff_set_touch_victim", victim_way, 1);
        lookup2(6'd9, 6'h01);
        check("diff_set_fill_hit", hit, 1);

        // Reset in the middle of a flush
        fill2(6'd60, 1'b1, 6'h33);
        inv_all = 1'b1;
        tick();
        inv_all = 1'b0;
        repeat (9) tick();
        check("flush10_busy", busy, 1);
        rst = 1'b0;
        #1;
        check("rst_flush_busy", busy, 0);
        check("rst_flush_done", lookup_done, 0);
        tick();
        rst = 1'b1;
        tick();
        lookup2(6'd60, 6'h33);
        check("rst_abort_hit60", hit, 0);
        check("rst_abort_victim60", victim_way, 0);
        lookup2(6'd5, 6'h2A);
        check("rst_abort_hit5", hit, 0);
        lookup4(6'd7, 6'h10);
        check("rst_w4_hit", hit4, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
